// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module   : seq_restoring_divider
// Purpose  : 4-bit unsigned sequential restoring divider, one quotient bit
//            per cycle, with divide-by-zero short-circuit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_restoring_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       dbz
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_DBZ_QUOTIENT = 4'hF;
    localparam logic [1:0] C_LAST_STEP    = 2'd3;

    state_t     state_q, state_d;
    logic [3:0] div_q, div_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] quo_q, quo_d;
    logic [1:0] step_q, step_d;
    logic [3:0] quotient_q, quotient_d;
    logic [3:0] remainder_q, remainder_d;
    logic       dbz_q, dbz_d;

    logic [3:0] w_shift_rem;
    logic [4:0] w_trial;
    logic       w_trial_neg;

    // The partial remainder before the last shift is below 8, so the bit
    // shifted out of R is always zero and a 4-bit R is sufficient.
    assign w_shift_rem = {rem_q[2:0], quo_q[3]};
    assign w_trial     = {1'b0, w_shift_rem} + {1'b1, ~div_q} + 5'd1;
    assign w_trial_neg = w_trial[4];

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        step_d      = step_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor != 4'd0) begin
                        div_d   = divisor;
                        rem_d   = 4'd0;
                        quo_d   = dividend;
                        step_d  = 2'd0;
                        state_d = ST_CALC;
                    end else begin
                        quotient_d  = C_DBZ_QUOTIENT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_CALC: begin
                rem_d  = w_trial_neg ? w_shift_rem : w_trial[3:0];
                quo_d  = {quo_q[2:0], ~w_trial_neg};
                step_d = step_q + 2'd1;
                if (step_q == C_LAST_STEP) begin
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= 4'd0;
            rem_q       <= 4'd0;
            quo_q       <= 4'd0;
            step_q      <= 2'd0;
            quotient_q  <= 4'd0;
            remainder_q <= 4'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            step_q      <= step_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module   : tb_seq_restoring_divider
// Purpose  : Self-checking bench for seq_restoring_divider against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    // Reference result packed as {quotient, remainder, dbz}.
    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
        if (b == 4'd0)
            return {4'hF, a, 1'b1};
        return {4'(a / b), 4'(a % b), 1'b0};
    endfunction

    function automatic int model_latency(input logic [3:0] b);
        return (b == 4'd0) ? 1 : 5;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the
    // DUT idle again. lat is 0 if no done pulse was seen.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         output int lat, output int busy_cnt,
                         output logic [8:0] res, output logic idle_after);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        lat      = 0;
        busy_cnt = 0;
        res      = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                res = {quotient, remainder, dbz};
                break;
            end
        end
        @(negedge clk);
        idle_after = !busy && !done;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({quotient, remainder, busy, done, dbz} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required 000", {quotient, remainder, busy, done, dbz});
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({quotient, remainder, busy, done, dbz} !== 11'd0) begin
            errors++;
            $display("FAIL reset_release_idle: got %h required 000", {quotient, remainder, busy, done, dbz});
        end
    endtask

    task automatic test_basic;
        int lat, bcnt;
        logic [8:0] res;
        logic idle;
        do_op(4'd13, 4'd4, lat, bcnt, res, idle);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 5", lat);
        end
        checks++;
        if (res !== {4'd3, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%0d required q=3 r=1 dbz=0", res[8:5], res[4:1], res[0]);
        end
        checks++;
        if (bcnt !== 5 || idle !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got busy_cycles=%0d idle_after=%0d required 5 and 1", bcnt, idle);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({quotient, remainder, dbz} !== {4'd3, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL basic_hold: got q=%0d r=%0d dbz=%0d required q=3 r=1 dbz=0", quotient, remainder, dbz);
        end
    endtask

    task automatic test_boundary_and_random;
        logic [3:0] av [3] = '{4'd15, 4'd3, 4'd15};
        logic [3:0] bv [3] = '{4'd1, 4'd7, 4'd15};
        int lat, bcnt;
        logic [8:0] res;
        logic idle;
        logic [3:0] a, b;
        for (int i = 0; i < 27; i++) begin
            if (i < 3) begin
                a = av[i];
                b = bv[i];
            end else begin
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
            end
            do_op(a, b, lat, bcnt, res, idle);
            checks++;
            if (lat !== model_latency(b)) begin
                errors++;
                $display("FAIL op_latency %0d/%0d: got %0d required %0d", a, b, lat, model_latency(b));
            end
            checks++;
            if (res !== model(a, b)) begin
                errors++;
                $display("FAIL op_result %0d/%0d: got %h required %h", a, b, res, model(a, b));
            end
        end
    endtask

    task automatic test_dbz;
        int lat, bcnt;
        logic [8:0] res;
        logic idle;
        do_op(4'd9, 4'd0, lat, bcnt, res, idle);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d required 1", lat);
        end
        checks++;
        if (res !== {4'hF, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL dbz_result: got %h required %h", res, {4'hF, 4'd9, 1'b1});
        end
        do_op(4'd6, 4'd3, lat, bcnt, res, idle);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL dbz_next_latency: got %0d required 5", lat);
        end
        checks++;
        if (res !== {4'd2, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL dbz_next_result: got %h required %h", res, {4'd2, 4'd0, 1'b0});
        end
    endtask

    task automatic test_start_in_calc;
        int n_done = 0;
        int first_k = 0;
        logic [8:0] res = '0;
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_k = k;
                    res = {quotient, remainder, dbz};
                end
            end
            start = (k == 2);
            if (k == 2) begin
                dividend = 4'd2;
                divisor  = 4'd1;
            end
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL calc_start_done_count: got %0d required 1", n_done);
        end
        checks++;
        if (first_k !== 5) begin
            errors++;
            $display("FAIL calc_start_latency: got %0d required 5", first_k);
        end
        checks++;
        if (res !== {4'd3, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL calc_start_result: got %h required %h", res, {4'd3, 4'd1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_calc;
        int lat, bcnt;
        int n_done = 0;
        logic [8:0] res;
        logic idle;
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, busy, done, dbz} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h required 000", {quotient, remainder, busy, done, dbz});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done cycles required 0", n_done);
        end
        rst_n = 1'b1;
        do_op(4'd8, 4'd3, lat, bcnt, res, idle);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL reset_mid_first_edge: got latency %0d required 5", lat);
        end
        checks++;
        if (res !== {4'd2, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_next_result: got %h required %h", res, {4'd2, 4'd2, 1'b0});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] p;
        logic [3:0] a, b;
        int gap, exp_gap;
        bit found;
        @(negedge clk);
        start = 1'b1;
        for (int idx = 0; idx < 256; idx++) begin
            p = 8'(idx);
            a = p[7:4];
            b = p[3:0];
            dividend = a;
            divisor  = b;
            if (idx == 0) exp_gap = model_latency(b);
            else          exp_gap = (b == 4'd0) ? 2 : 6;
            found = 1'b0;
            gap   = 0;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (done) begin
                    found = 1'b1;
                    gap   = k;
                    break;
                end
            end
            checks++;
            if (!found || gap !== exp_gap) begin
                errors++;
                $display("FAIL sweep_spacing %0d/%0d: got %0d required %0d", a, b, gap, exp_gap);
                if (!found) begin
                    start = 1'b0;
                    return;
                end
            end
            checks++;
            if ({quotient, remainder, dbz} !== model(a, b)) begin
                errors++;
                $display("FAIL sweep_result %0d/%0d: got %h required %h", a, b, {quotient, remainder, dbz}, model(a, b));
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        test_reset();
        test_basic();
        test_boundary_and_random();
        test_dbz();
        test_start_in_calc();
        test_reset_mid_calc();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
